stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 500000, clk cycles per count tick (50 MHz / 100 Hz = 10 ms tick).
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000, consecutive stable samples required to accept a button level (20 ms).
REQ-003 clk  input  1  system clock, 50 MHz; all logic on rising edge; single clock domain.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-005 button_start  input  1  raw, asynchronous, active-high start button.
REQ-006 button_stop  input  1  raw, asynchronous, active-high stop button.
REQ-007 button_reset  input  1  raw, asynchronous, active-high user clear button; distinct from rst_n.
REQ-008 count_en  output  1  one-cycle pulse; the downstream BCD time counter increments by one.
REQ-009 count_clr  output  1  one-cycle pulse; the downstream time counter clears to zero.
REQ-010 running  output  1  high while state is RUN.
REQ-011 state  output  2  current FSM state: IDLE=2'b00, RUN=2'b01, PAUSED=2'b10; 2'b11 is never driven.

Function
REQ-012 Each button passes through a two-flop synchronizer before any other use.
REQ-013 Each synchronized button has its own debounce counter, width ceil(log2(DEBOUNCE_CYCLES+1)): counter clears when the sample equals the accepted level, otherwise increments; when it reaches DEBOUNCE_CYCLES the accepted level takes the sample and the counter clears.
REQ-014 Press event: one-cycle registered pulse on the 0->1 transition of an accepted level; a 1->0 transition generates no event.
REQ-015 Glitches shorter than DEBOUNCE_CYCLES cycles produce no event; a held button produces exactly one event.
REQ-016 FSM transitions take effect on the clk edge following the press-event cycle:
  - any state + reset event -> IDLE, count_clr pulses that same edge
  - IDLE + start -> RUN
  - RUN + stop -> PAUSED
  - PAUSED + start -> RUN
  - all other event/state combinations: no change (start in RUN, stop in IDLE/PAUSED ignored).
REQ-017 Simultaneous events: priority reset > stop > start; in PAUSED, start+stop together leaves the state in PAUSED.
REQ-018 count_clr also pulses on a reset event while already in IDLE.
REQ-019 Prescaler width ceil(log2(TICK_DIV)); increments each cycle in RUN; when it equals TICK_DIV-1 it wraps to 0 and count_en pulses for that cycle.
REQ-020 First count_en after IDLE->RUN occurs exactly TICK_DIV cycles after state first reads RUN; thereafter every TICK_DIV cycles.
REQ-021 Prescaler holds its value in PAUSED (resume continues the partial tick) and is cleared to 0 in IDLE.
REQ-022 count_en never asserts outside RUN; count_en and count_clr are never high in the same cycle.
REQ-023 RUN->PAUSED on the cycle a tick would fire: that tick is still emitted (transition takes effect next edge).

Reset
REQ-024 rst_n low on a rising edge: state=IDLE, running=0, count_en=0, count_clr=0, prescaler=0, debounce counters=0, accepted levels=0, synchronizers=0, pending events=0.
REQ-025 A reset mid-operation (any state, any prescaler value) discards pending press events; no count_en or count_clr pulse follows from pre-reset activity.
REQ-026 Buttons held across rst_n release are accepted as new presses after the full debounce period.

Verification (TICK_DIV=10, DEBOUNCE_CYCLES=4)
REQ-027 Reset then idle 50 cycles -> state=00, running=0, count_en and count_clr never asserted.
REQ-028 start held 20 cycles -> one event, state=01; count_en pulses every 10 cycles, first 10 cycles after RUN entry; 55 cycles in RUN -> exactly 5 pulses.
REQ-029 start pulses of 3 cycles repeated in IDLE -> no event, state stays 00.
REQ-030 RUN with prescaler=6, stop press -> PAUSED, prescaler holds 6; start press -> RUN, next count_en 4 cycles after re-entry.
REQ-031 start, stop, reset accepted in the same cycle while in RUN -> state=00, single count_clr pulse, no further count_en.
REQ-032 rst_n asserted for 1 cycle while in RUN with prescaler=8 -> next cycle state=00, prescaler=0, no count_en.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: synchronizes and debounces three push buttons, runs the
// IDLE/RUN/PAUSED state machine and emits count_en / count_clr pulses for a
// downstream BCD time counter.
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV        = 500000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       button_start,
  input  logic       button_stop,
  input  logic       button_reset,
  output logic       count_en,
  output logic       count_clr,
  output logic       running,
  output logic [1:0] state
);

  localparam int unsigned NB   = 3;
  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  // Button bit positions within the synchronized / debounced vectors
  localparam int unsigned B_START = 0;
  localparam int unsigned B_STOP  = 1;
  localparam int unsigned B_RESET = 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_PAUSED = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic [NB-1:0]     sync1_q, sync1_d;
  logic [NB-1:0]     sync2_q, sync2_d;
  logic [NB-1:0]     lvl_q, lvl_d;
  logic [NB-1:0]     ev_q, ev_d;
  logic [DB_W-1:0]   db_cnt_q [NB];
  logic [DB_W-1:0]   db_cnt_d [NB];
  logic [PS_W-1:0]   presc_q, presc_d;
  logic              count_en_q, count_en_d;
  logic              count_clr_q, count_clr_d;
  logic              running_q, running_d;
  logic              wrap;

  assign wrap = (presc_q == PS_W'(TICK_DIV - 1));

  // Two-flop synchronizer, debounce counters and press-event detection
  always_comb begin
    sync1_d = {button_reset, button_stop, button_start};
    sync2_d = sync1_q;
    lvl_d   = lvl_q;
    for (int i = 0; i < int'(NB); i++) begin
      db_cnt_d[i] = db_cnt_q[i];
      if (sync2_q[i] == lvl_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        lvl_d[i]    = sync2_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
      end
    end
    ev_d = lvl_d & ~lvl_q;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: reset > stop > start; stop blocks start even where stop is ignored
  always_comb begin
    state_d = state_q;
    if (ev_q[B_RESET]) begin
      state_d = S_IDLE;
    end else if (ev_q[B_STOP]) begin
      if (state_q == S_RUN) state_d = S_PAUSED;
    end else if (ev_q[B_START]) begin
      if (state_q != S_RUN) state_d = S_RUN;
    end
  end

  // Prescaler and output pulses; a user clear overrides a coincident tick
  always_comb begin
    presc_d     = presc_q;
    count_en_d  = 1'b0;
    count_clr_d = 1'b0;
    running_d   = (state_d == S_RUN);
    case (state_q)
      S_IDLE: presc_d = '0;
      S_RUN: begin
        if (wrap) begin
          presc_d    = '0;
          count_en_d = 1'b1;
        end else begin
          presc_d = presc_q + PS_W'(1);
        end
      end
      default: presc_d = presc_q;
    endcase
    if (ev_q[B_RESET]) begin
      presc_d     = '0;
      count_en_d  = 1'b0;
      count_clr_d = 1'b1;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      lvl_q       <= '0;
      ev_q        <= '0;
      presc_q     <= '0;
      count_en_q  <= 1'b0;
      count_clr_q <= 1'b0;
      running_q   <= 1'b0;
      for (int i = 0; i < int'(NB); i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      lvl_q       <= lvl_d;
      ev_q        <= ev_d;
      presc_q     <= presc_d;
      count_en_q  <= count_en_d;
      count_clr_q <= count_clr_d;
      running_q   <= running_d;
      for (int i = 0; i < int'(NB); i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  assign count_en  = count_en_q;
  assign count_clr = count_clr_q;
  assign running   = running_q;
  assign state     = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=10, DEBOUNCE_CYCLES=4.
module tb_stopwatch_ctrl;

  localparam int unsigned TICK_DIV = 10;
  localparam int unsigned DEB      = 4;

  logic       clk;
  logic       rst_n;
  logic       btn_start, btn_stop, btn_reset;
  logic       count_en, count_clr, running;
  logic [1:0] state;

  int ntests = 0;
  int nfail  = 0;
  int en_cnt = 0;
  int clr_cnt = 0;
  int both_cnt = 0;

  stopwatch_ctrl #(.TICK_DIV(TICK_DIV), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .button_start (btn_start),
    .button_stop  (btn_stop),
    .button_reset (btn_reset),
    .count_en     (count_en),
    .count_clr    (count_clr),
    .running      (running),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle
  always @(negedge clk) begin
    if (count_en) en_cnt++;
    if (count_clr) clr_cnt++;
    if (count_en && count_clr) both_cnt++;
  end

  typedef struct {
    logic       s;
    logic       p;
    logic       r;
    int         hold;
    logic [1:0] exp_state;
    int         exp_clr;
  } vec_t;

  vec_t vecs [14];

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic check(input string name, input int act, input int exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_state(input logic [1:0] s, input int max, output int n);
    n = 0;
    while (state != s && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_en(input int max, output int n);
    n = 0;
    while (!count_en && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic press(input logic s, input logic p, input logic r, input int hold);
    btn_start = s; btn_stop = p; btn_reset = r;
    ticks(hold);
    btn_start = 1'b0; btn_stop = 1'b0; btn_reset = 1'b0;
    ticks(12);
  endtask

  initial begin
    int e0, c0, n, idx, first, r1, r2;

    vecs[0]  = '{0, 0, 1, 8, 2'b00, 1};
    vecs[1]  = '{0, 1, 0, 8, 2'b00, 0};
    vecs[2]  = '{0, 0, 1, 8, 2'b00, 1};
    vecs[3]  = '{1, 0, 0, 3, 2'b00, 0};
    vecs[4]  = '{1, 0, 0, 8, 2'b01, 0};
    vecs[5]  = '{1, 0, 0, 8, 2'b01, 0};
    vecs[6]  = '{0, 1, 0, 8, 2'b10, 0};
    vecs[7]  = '{0, 1, 0, 8, 2'b10, 0};
    vecs[8]  = '{1, 1, 0, 8, 2'b10, 0};
    vecs[9]  = '{1, 0, 0, 8, 2'b01, 0};
    vecs[10] = '{0, 1, 0, 2, 2'b01, 0};
    vecs[11] = '{0, 1, 1, 8, 2'b00, 1};
    vecs[12] = '{1, 0, 0, 8, 2'b01, 0};
    vecs[13] = '{1, 1, 1, 8, 2'b00, 1};

    rst_n = 1'b0; btn_start = 1'b0; btn_stop = 1'b0; btn_reset = 1'b0;
    ticks(3);
    check("rst_state", int'(state), 0);
    check("rst_running", int'(running), 0);
    check("rst_count_en", int'(count_en), 0);
    check("rst_count_clr", int'(count_clr), 0);
    rst_n = 1'b1;

    // Idle quietly
    e0 = en_cnt; c0 = clr_cnt;
    ticks(50);
    check("idle_state", int'(state), 0);
    check("idle_running", int'(running), 0);
    check("idle_no_en", en_cnt - e0, 0);
    check("idle_no_clr", clr_cnt - c0, 0);

    // Short glitches never accepted
    for (int k = 0; k < 5; k++) begin
      btn_start = 1'b1; ticks(3);
      btn_start = 1'b0; ticks(1);
    end
    ticks(10);
    check("glitch_state", int'(state), 0);

    // Held start: one event, then a tick every TICK_DIV cycles
    e0 = en_cnt;
    btn_start = 1'b1;
    wait_state(2'b01, 20, n);
    check("start_to_run", int'(state), 1);
    check("run_entry_en", int'(count_en), 0);
    first = -1;
    for (idx = 1; idx < 55; idx++) begin
      if (n + idx >= 20) btn_start = 1'b0;
      tick();
      if (count_en && first < 0) first = idx;
    end
    check("first_tick_delay", first, 10);
    check("ticks_in_55", en_cnt - e0, 5);
    check("run_state_held", int'(state), 1);
    check("run_running", int'(running), 1);

    // Pause mid-interval then resume: partial tick is preserved
    wait_en(12, n);
    check("pause_sync_en", int'(count_en), 1);
    btn_stop = 1'b1;
    r1 = 1;
    n = 0;
    tick();
    while (state == 2'b01 && n < 20) begin
      r1++;
      n++;
      tick();
    end
    check("stop_to_paused", int'(state), 2);
    btn_stop = 1'b0;
    ticks(1);
    e0 = en_cnt;
    ticks(20);
    check("paused_no_en", en_cnt - e0, 0);
    check("paused_running", int'(running), 0);
    btn_start = 1'b1;
    wait_state(2'b01, 20, n);
    check("resume_to_run", int'(state), 1);
    r2 = 0;
    n = 0;
    while (!count_en && n < 20) begin
      if (state == 2'b01) r2++;
      n++;
      tick();
      if (n == 8) btn_start = 1'b0;
    end
    check("resume_tick_total", r1 + r2, int'(TICK_DIV));
    btn_start = 1'b0;
    ticks(10);

    // Table of button presses with state and clear expectations
    foreach (vecs[i]) begin
      c0 = clr_cnt;
      press(vecs[i].s, vecs[i].p, vecs[i].r, vecs[i].hold);
      check($sformatf("vec%0d_state", i), int'(state), int'(vecs[i].exp_state));
      check($sformatf("vec%0d_running", i), int'(running), int'(vecs[i].exp_state == 2'b01));
      check($sformatf("vec%0d_clr", i), clr_cnt - c0, vecs[i].exp_clr);
    end
    e0 = en_cnt; c0 = clr_cnt;
    ticks(30);
    check("after_clear_no_en", en_cnt - e0, 0);
    check("after_clear_no_clr", clr_cnt - c0, 0);

    // rst_n pulse in RUN with prescaler at 8
    press(1'b1, 1'b0, 1'b0, 8);
    check("pre_rst_run", int'(state), 1);
    wait_en(12, n);
    check("pre_rst_sync_en", int'(count_en), 1);
    ticks(8);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rstn_state", int'(state), 0);
    check("rstn_running", int'(running), 0);
    check("rstn_count_en", int'(count_en), 0);
    e0 = en_cnt; c0 = clr_cnt;
    ticks(20);
    check("rstn_no_en", en_cnt - e0, 0);
    check("rstn_no_clr", clr_cnt - c0, 0);
    check("rstn_state_hold", int'(state), 0);

    // Button held across rst_n release is a new press after full debounce
    btn_start = 1'b1;
    ticks(3);
    rst_n = 1'b0;
    ticks(2);
    rst_n = 1'b1;
    check("held_rst_idle", int'(state), 0);
    wait_state(2'b01, 15, n);
    check("held_rst_run", int'(state), 1);
    check("held_rst_debounced", int'(n >= int'(DEB) + 2), 1);
    btn_start = 1'b0;
    ticks(10);

    check("en_clr_exclusive", both_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
